// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared tri-state data bus: grants one
// source at a time, holds its oe, strobes the destination load, then idles one gap.
//
//   state | meaning
//   IDLE  | waiting for any req; grant search starts at ptr
//   DRIVE | oe[g] held for HOLD cycles, ld on the last one
//   GAP   | bus released, ack[g] pulses, transfer counted
module bus_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int HOLD  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] oe,
  output logic             ld,
  output logic [N_REQ-1:0] ack,
  output logic [2:0]       gnt_id,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  localparam logic [3:0]       N_REQ4  = 4'(N_REQ);
  localparam logic [3:0]       HOLD4   = 4'(HOLD);
  localparam logic [2:0]       LAST_ID = 3'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_N   = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [3:0]       hold_q, hold_d;
  logic [N_REQ-1:0] oe_q, oe_d;
  logic             ld_q, ld_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [2:0]       gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  logic [N_REQ-1:0] req_rot;
  logic [2:0]       off;
  logic [3:0]       sum;
  logic [2:0]       pick;

  // Rotate req so bit 0 is the source at ptr; the lowest set bit is the winner.
  always_comb begin
    req_rot = N_REQ'({req, req} >> ptr_q);
    off = 3'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) off = 3'(k);
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= N_REQ4) sum = sum - N_REQ4;
    pick = sum[2:0];
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    oe_d       = oe_q;
    ld_d       = 1'b0;
    ack_d      = '0;
    gnt_id_d   = gnt_id_q;
    busy_d     = busy_q;
    xfer_cnt_d = xfer_cnt_q;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_d  = DRIVE;
          oe_d     = ONE_N << pick;
          gnt_id_d = pick;
          busy_d   = 1'b1;
          hold_d   = 4'd1;
          ld_d     = (HOLD4 == 4'd1);
        end
      end
      DRIVE: begin
        if (hold_q == HOLD4) begin
          state_d    = GAP;
          oe_d       = '0;
          ack_d      = ONE_N << gnt_id_q;
          xfer_cnt_d = xfer_cnt_q + ONE_C;
          ptr_d      = (gnt_id_q == LAST_ID) ? 3'd0 : gnt_id_q + 3'd1;
          hold_d     = 4'd0;
        end else begin
          hold_d = hold_q + 4'd1;
          ld_d   = (hold_q + 4'd1 == HOLD4);
        end
      end
      GAP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        oe_d    = '0;
        busy_d  = 1'b0;
        hold_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd0;
      hold_q     <= 4'd0;
      oe_q       <= '0;
      ld_q       <= 1'b0;
      ack_q      <= '0;
      gnt_id_q   <= 3'd0;
      busy_q     <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      oe_q       <= oe_d;
      ld_q       <= ld_d;
      ack_q      <= ack_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign oe       = oe_q;
  assign ld       = ld_q;
  assign ack      = ack_q;
  assign gnt_id   = gnt_id_q;
  assign busy     = busy_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule
